// File: rtl/access_sequencer_pkg.sv
// ============================================================================
// access_sequencer_pkg : command codes, address-generator modes, depth codes
// Rev 1.0
// ============================================================================
`default_nettype none

package access_sequencer_pkg;

    localparam int LOAD_BEATS = 2048;

    typedef enum logic [3:0] {
        OP_LOAD       = 4'd0,
        OP_RIGHT      = 4'd1,
        OP_LEFT       = 4'd2,
        OP_UP         = 4'd3,
        OP_DOWN       = 4'd4,
        OP_DEPTH_DOWN = 4'd5,
        OP_DEPTH_UP   = 4'd6,
        OP_DISPLAY    = 4'd7,
        OP_CONV       = 4'd8
    } op_e;

    localparam logic [1:0] MODE_LOAD = 2'd0;
    localparam logic [1:0] MODE_DISP = 2'd1;
    localparam logic [1:0] MODE_CONV = 2'd2;
    localparam logic [1:0] MODE_IDLE = 2'd3;

    localparam logic [1:0] DEPTH_32 = 2'd0;
    localparam logic [1:0] DEPTH_16 = 2'd1;
    localparam logic [1:0] DEPTH_8  = 2'd2;

    localparam logic [2:0] POS_MAX = 3'd6;

    // Final count of a display (4 per channel) or conv (16 per channel) pass;
    // halving the channel count is a right shift of the 32-channel terminal.
    function automatic logic [10:0] last_count(input logic [1:0] depth, input logic conv);
        logic [10:0] base;
        base = conv ? 11'd511 : 11'd127;
        return base >> depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/access_sequencer_view_regs.sv
// ============================================================================
// view_regs : saturating origin (row/col 0..6) and channel-depth registers
// Rev 1.0
// ============================================================================
`default_nettype none

module view_regs
    import access_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update,
    input  logic [3:0] op,
    output logic [5:0] origin,
    output logic [1:0] depth
);

    logic [2:0] row;
    logic [2:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= 3'd0;
            col   <= 3'd0;
            depth <= DEPTH_32;
        end else if (update) begin
            case (op)
                OP_RIGHT:      if (col != POS_MAX) col <= col + 3'd1;
                OP_LEFT:       if (col != 3'd0)    col <= col - 3'd1;
                OP_UP:         if (row != 3'd0)    row <= row - 3'd1;
                OP_DOWN:       if (row != POS_MAX) row <= row + 3'd1;
                OP_DEPTH_DOWN: if (depth != DEPTH_8)  depth <= depth + 2'd1;
                OP_DEPTH_UP:   if (depth != DEPTH_32) depth <= depth - 2'd1;
                default: ;
            endcase
        end
    end

    assign origin = {row, col};

endmodule

`default_nettype wire

// File: rtl/access_sequencer.sv
// ============================================================================
// access_sequencer : command FSM driving the image-buffer address generator
// Rev 1.0
// ============================================================================
`default_nettype none

module access_sequencer #(
    parameter int LOAD_BEATS = access_sequencer_pkg::LOAD_BEATS
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_op_valid,
    input  logic [3:0]  i_op_mode,
    output logic        o_op_ready,
    input  logic        i_in_valid,
    output logic [10:0] o_counter,
    output logic [1:0]  o_mode,
    output logic [5:0]  o_origin,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [1:0]  o_depth,
    output logic        o_last,
    output logic        o_op_done
);
    import access_sequencer_pkg::*;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_DISP = 3'd2,
        S_CONV = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [10:0] LOAD_LAST = 11'(LOAD_BEATS - 1);

    state_e      state;
    logic [10:0] counter;
    logic [10:0] term;
    logic        accept;
    logic        streaming;

    assign accept    = (state == S_IDLE) && i_op_valid;
    assign streaming = (state == S_DISP) || (state == S_CONV);

    view_regs u_view_regs (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .update (accept),
        .op     (i_op_mode),
        .origin (o_origin),
        .depth  (o_depth)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            counter <= 11'd0;
            term    <= 11'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    counter <= 11'd0;
                    if (i_op_valid) begin
                        case (i_op_mode)
                            OP_LOAD:    state <= S_LOAD;
                            OP_DISPLAY: begin
                                state <= S_DISP;
                                term  <= last_count(o_depth, 1'b0);
                            end
                            OP_CONV: begin
                                state <= S_CONV;
                                term  <= last_count(o_depth, 1'b1);
                            end
                            default:    state <= S_DONE;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) begin
                        if (counter == LOAD_LAST) begin
                            state   <= S_DONE;
                            counter <= 11'd0;
                        end else begin
                            counter <= counter + 11'd1;
                        end
                    end
                end
                S_DISP, S_CONV: begin
                    // Terminal compare first, so the counter never wraps.
                    if (counter == term) begin
                        state   <= S_DONE;
                        counter <= 11'd0;
                    end else begin
                        counter <= counter + 11'd1;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    counter <= 11'd0;
                end
                default: begin
                    state   <= S_IDLE;
                    counter <= 11'd0;
                end
            endcase
        end
    end

    always_comb begin
        o_mode = MODE_IDLE;
        case (state)
            S_LOAD:  o_mode = MODE_LOAD;
            S_DISP:  o_mode = MODE_DISP;
            S_CONV:  o_mode = MODE_CONV;
            default: o_mode = MODE_IDLE;
        endcase
    end

    assign o_counter  = counter;
    assign o_op_ready = (state == S_IDLE);
    assign o_op_done  = (state == S_DONE);
    assign o_mem_en   = (state == S_LOAD) ? i_in_valid : streaming;
    assign o_mem_we   = (state == S_LOAD) && i_in_valid;
    assign o_last     = (state == S_LOAD) ? (i_in_valid && (counter == LOAD_LAST))
                                          : (streaming && (counter == term));

endmodule

`default_nettype wire

// File: tb/tb_access_sequencer.sv
// ============================================================================
// tb_access_sequencer : directed + randomized checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_access_sequencer;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [3:0]  op_mode;
    logic        op_ready;
    logic        in_valid;
    logic [10:0] counter;
    logic [1:0]  mode;
    logic [5:0]  origin;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  depth;
    logic        last;
    logic        op_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model: view position and channel count.
    int m_row = 0;
    int m_col = 0;
    int m_ch  = 32;

    access_sequencer #(.LOAD_BEATS(2048)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_op_valid (op_valid),
        .i_op_mode  (op_mode),
        .o_op_ready (op_ready),
        .i_in_valid (in_valid),
        .o_counter  (counter),
        .o_mode     (mode),
        .o_origin   (origin),
        .o_mem_en   (mem_en),
        .o_mem_we   (mem_we),
        .o_depth    (depth),
        .o_last     (last),
        .o_op_done  (op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_depth();
        return (m_ch == 32) ? 0 : (m_ch == 16) ? 1 : 2;
    endfunction

    task automatic model_apply(input int m);
        case (m)
            1: m_col = (m_col < 6) ? m_col + 1 : 6;
            2: m_col = (m_col > 0) ? m_col - 1 : 0;
            3: m_row = (m_row > 0) ? m_row - 1 : 0;
            4: m_row = (m_row < 6) ? m_row + 1 : 6;
            5: m_ch  = (m_ch > 8)  ? m_ch / 2 : 8;
            6: m_ch  = (m_ch < 32) ? m_ch * 2 : 32;
            default: ;
        endcase
    endtask

    task automatic chk_view(input string tag);
        chk({tag, "_origin"}, origin, m_row * 8 + m_col);
        chk({tag, "_depth"}, depth, exp_depth());
    endtask

    // Presents a command in an IDLE cycle; DUT leaves IDLE at the next edge.
    task automatic accept(input int m);
        op_valid = 1'b1;
        op_mode  = 4'(m);
        #1;
        chk("ready_idle", op_ready, 1);
        chk("done_idle", op_done, 0);
        chk("mode_idle", mode, 3);
        tick;
        op_valid = 1'b0;
        model_apply(m);
    endtask

    task automatic expect_done(input string tag);
        op_valid = 1'b0;
        in_valid = 1'b0;
        #1;
        chk({tag, "_done"}, op_done, 1);
        chk({tag, "_done_mem_en"}, mem_en, 0);
        chk({tag, "_done_mode"}, mode, 3);
        chk({tag, "_done_counter"}, counter, 0);
        chk_view(tag);
        tick;
    endtask

    // Display or conv pass; abort_at >= 0 asserts reset at that count.
    task automatic run_stream(input bit conv, input bit hold_valid, input int abort_at);
        int term;
        term = (conv ? 16 : 4) * m_ch - 1;
        for (int i = 0; i <= term; i++) begin
            if (hold_valid) begin
                op_valid = 1'b1;
                op_mode  = 4'($urandom_range(0, 15));
            end
            #1;
            chk("stream_counter", counter, i);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_counter", counter, 0);
                chk("abort_mode", mode, 3);
                chk("abort_done", op_done, 0);
                chk("abort_mem_en", mem_en, 0);
                return;
            end
            chk("stream_mode", mode, conv ? 2 : 1);
            chk("stream_mem_en", mem_en, 1);
            chk("stream_mem_we", mem_we, 0);
            chk("stream_last", last, (i == term) ? 1 : 0);
            chk("stream_ready", op_ready, 0);
            chk("stream_done", op_done, 0);
            chk_view("stream");
            tick;
        end
        expect_done(conv ? "conv" : "disp");
    endtask

    bit gap_before[2048];

    initial begin
        int n;
        int m;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_mode  = 4'd0;
        in_valid = 1'b0;

        // Reset state
        repeat (3) tick;
        #1;
        chk("rst_counter", counter, 0);
        chk("rst_mode", mode, 3);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_last", last, 0);
        chk("rst_done", op_done, 0);
        chk_view("rst");
        rst_n = 1'b1;
        tick;

        // Load of 2048 beats with 10 randomly placed idle gaps
        n = 0;
        while (n < 10) begin
            m = $urandom_range(1, 2047);
            if (!gap_before[m]) begin
                gap_before[m] = 1'b1;
                n++;
            end
        end
        accept(0);
        for (int b = 0; b < 2048; b++) begin
            if (gap_before[b]) begin
                in_valid = 1'b0;
                #1;
                chk("load_gap_mem_en", mem_en, 0);
                chk("load_gap_counter", counter, b);
                chk("load_gap_last", last, 0);
                chk("load_gap_mode", mode, 0);
                tick;
            end
            in_valid = 1'b1;
            #1;
            chk("load_counter", counter, b);
            chk("load_mem_en", mem_en, 1);
            chk("load_mem_we", mem_we, 1);
            chk("load_last", last, (b == 2047) ? 1 : 0);
            chk("load_ready", op_ready, 0);
            tick;
        end
        expect_done("load");

        // Right x7 from origin 0: saturates at column 6
        for (int k = 1; k <= 7; k++) begin
            accept(1);
            expect_done("right");
            if (k >= 6) chk("right_sat", origin, 6);
        end

        // Depth down x3 saturates at 8 channels, then display with op_valid held
        for (int k = 0; k < 3; k++) begin
            accept(5);
            expect_done("ddown");
        end
        chk("depth8", depth, 2);
        accept(7);
        run_stream(1'b0, 1'b1, -1);

        // Back to 32 channels, then a full conv pass
        for (int k = 0; k < 3; k++) begin
            accept(6);
            expect_done("dup");
        end
        chk("depth32", depth, 0);
        accept(8);
        run_stream(1'b1, 1'b0, -1);

        // Illegal code is a no-op with a done pulse
        accept(12);
        expect_done("illegal");

        // Random navigation, illegal codes and short display/conv passes
        for (int k = 0; k < 40; k++) begin
            m = $urandom_range(1, 15);
            if (m == 7 || m == 8) begin
                accept(m);
                run_stream(m == 8, 1'b0, -1);
            end else begin
                accept(m);
                expect_done("rand");
            end
        end

        // Reset mid-conv at count 100
        while (m_ch != 32) begin
            accept(6);
            expect_done("dup2");
        end
        accept(8);
        run_stream(1'b1, 1'b0, 100);
        for (int k = 0; k < 2; k++) begin
            tick;
            chk("rst_hold_done", op_done, 0);
        end
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        m_ch  = 32;
        #1;
        chk("post_rst_ready", op_ready, 1);
        chk("post_rst_counter", counter, 0);
        chk_view("post_rst");
        tick;
        chk("post_rst_done", op_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
